// File: rtl/fixp_add_relu_pipe_pkg.sv
// rtl/fixp_add_relu_pipe_pkg.sv - shared types and helpers for the fixed-point add/ReLU pipeline
package fixp_pkg;

    // Accumulate FSM encoding
    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } acc_state_t;

    // Stage-1 operation selected per beat by the shared control
    typedef enum logic [1:0] {
        OP_PASS      = 2'd0,
        OP_ADD       = 2'd1,
        OP_ACC_FIRST = 2'd2,
        OP_ACC_NEXT  = 2'd3
    } lane_op_t;

    // Width of the signed integer field of a lane word
    function automatic int int_w(input int data_w, input int frac_drop);
        return data_w - frac_drop;
    endfunction

    // Largest value representable in a w-bit signed field
    function automatic longint sat_max(input int w);
        return (longint'(1) << (w - 1)) - 1;
    endfunction

    // Smallest value representable in a w-bit signed field
    function automatic longint sat_min(input int w);
        return -(longint'(1) << (w - 1));
    endfunction

    // LSB position of lane k in a packed multi-lane bus
    function automatic int lane_lo(input int k, input int data_w);
        return k * data_w;
    endfunction

endpackage

// File: rtl/fixp_add_relu_pipe_if.sv
// rtl/fixp_add_relu_pipe_if.sv - beat/operand/result bundle of the add/ReLU pipeline
interface fixp_add_relu_pipe_if #(
    parameter int DATA_W    = 12,
    parameter int LANES     = 4,
    parameter int ACC_LEN_W = 8
);
    logic                     valid_i;
    logic [LANES*DATA_W-1:0]  data_1_i;
    logic [LANES*DATA_W-1:0]  data_2_i;
    logic                     add_en_i;
    logic                     relu_en_i;
    logic                     acc_en_i;
    logic [ACC_LEN_W-1:0]     acc_len_i;
    logic                     valid_o;
    logic [LANES*DATA_W-1:0]  data_sum_o;

    modport master (
        output valid_i, data_1_i, data_2_i, add_en_i, relu_en_i, acc_en_i, acc_len_i,
        input  valid_o, data_sum_o
    );

    modport slave (
        input  valid_i, data_1_i, data_2_i, add_en_i, relu_en_i, acc_en_i, acc_len_i,
        output valid_o, data_sum_o
    );
endinterface

// File: rtl/fixp_lane_add.sv
// rtl/fixp_lane_add.sv - one lane: pass/add/accumulate, saturation (FIXP_ADD_SAT_EN) and ReLU
module fixp_lane_add
    import fixp_pkg::*;
#(
    parameter int DATA_W    = 12,
    parameter int FRAC_DROP = 4,
    parameter int ACC_LEN_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  lane_op_t          op,
    input  logic              acc_step,   // valid beat in accumulate mode
    input  logic              emit,       // this beat produces a stage-1 result
    input  logic              relu,       // ReLU flag of the beat held in stage 1
    output logic [DATA_W-1:0] relu_out
);
    localparam int I_W = int_w(DATA_W, FRAC_DROP);
`ifdef FIXP_ADD_SAT_EN
    // Headroom so a full-length accumulation never wraps before the clamp
    localparam int ACC_W = I_W + ACC_LEN_W;
    localparam int W_W   = ACC_W + 1;
    localparam logic signed [W_W-1:0] SAT_HI = W_W'(sat_max(I_W));
    localparam logic signed [W_W-1:0] SAT_LO = W_W'(sat_min(I_W));
`else
    localparam int ACC_W = I_W;
    localparam int W_W   = I_W;
`endif

    logic signed [I_W-1:0]   a_int, b_int;
    logic signed [ACC_W-1:0] acc, acc_next, a_ext;
    logic signed [W_W-1:0]   add_sum;
    logic [DATA_W-1:0]       s1, s1_next;
    logic                    unused_frac;

    assign a_int       = a[DATA_W-1:FRAC_DROP];
    assign b_int       = b[DATA_W-1:FRAC_DROP];
    assign unused_frac = ^b[FRAC_DROP-1:0];
    assign a_ext       = ACC_W'(a_int);
    assign acc_next    = (op == OP_ACC_FIRST) ? a_ext : acc + a_ext;
    assign add_sum     = W_W'(a_int) + W_W'(b_int);

    // Reduce a wide signed result to the integer field: clamp or wrap
    function automatic logic [I_W-1:0] fit(input logic signed [W_W-1:0] v);
`ifdef FIXP_ADD_SAT_EN
        if (v > SAT_HI) return SAT_HI[I_W-1:0];
        if (v < SAT_LO) return SAT_LO[I_W-1:0];
`endif
        return v[I_W-1:0];
    endfunction

    // Stage-1 result for the current beat
    always_comb begin
        s1_next = a;
        case (op)
            OP_PASS: s1_next = a;
            OP_ADD:  s1_next = {fit(add_sum), {FRAC_DROP{1'b0}}};
            default: s1_next = {fit(W_W'(acc_next)), {FRAC_DROP{1'b0}}};
        endcase
    end

    // Accumulator and stage-1 register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc <= '0;
            s1  <= '0;
        end else begin
            if (acc_step) acc <= acc_next;
            if (emit)     s1  <= s1_next;
        end
    end

    // Stage-2 input: ReLU clamps negative results of flagged beats
    assign relu_out = (relu && s1[DATA_W-1]) ? '0 : s1;
endmodule

// File: rtl/fixp_add_relu_pipe.sv
// rtl/fixp_add_relu_pipe.sv - multi-lane fixed-point add/accumulate/ReLU pipeline top
module fixp_add_relu_pipe
    import fixp_pkg::*;
#(
    parameter int DATA_W     = 12,
    parameter int FRAC_DROP  = 4,
    parameter int LANES      = 4,
    parameter int PIPE_DEPTH = 5,
    parameter int ACC_LEN_W  = 8
) (
    input logic                  clk_i,
    input logic                  rst_i,
    fixp_add_relu_pipe_if.slave  bus
);
    acc_state_t             state;
    logic [ACC_LEN_W-1:0]   beat_cnt, len, cnt_inc;
    lane_op_t               op;
    logic                   emit, acc_step;
    logic                   vld1, relu1;
    logic [LANES*DATA_W-1:0] s2_next;
    logic [PIPE_DEPTH:2]    vld;
    logic [LANES*DATA_W-1:0] dly [2:PIPE_DEPTH];

    assign cnt_inc = beat_cnt + ACC_LEN_W'(1);

    // Decode the beat's operation and whether it produces a result
    always_comb begin
        op       = OP_PASS;
        emit     = 1'b0;
        acc_step = 1'b0;
        if (bus.acc_en_i) begin
            acc_step = bus.valid_i;
            if (state == IDLE) begin
                op   = OP_ACC_FIRST;
                emit = bus.valid_i && (bus.acc_len_i == '0);
            end else begin
                op   = OP_ACC_NEXT;
                emit = bus.valid_i && (cnt_inc == len);
            end
        end else begin
            op   = bus.add_en_i ? OP_ADD : OP_PASS;
            emit = bus.valid_i;
        end
    end

    // Accumulate FSM with beat counter; also registers stage-1 valid and ReLU tag
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            beat_cnt <= '0;
            len      <= '0;
            vld1     <= 1'b0;
            relu1    <= 1'b0;
        end else begin
            vld1 <= emit;
            if (emit) relu1 <= bus.relu_en_i;
            if (bus.valid_i) begin
                if (!bus.acc_en_i) begin
                    state <= IDLE;
                end else if (state == IDLE) begin
                    len      <= bus.acc_len_i;
                    beat_cnt <= '0;
                    state    <= (bus.acc_len_i == '0) ? IDLE : ACC;
                end else begin
                    beat_cnt <= cnt_inc;
                    if (cnt_inc == len) state <= IDLE;
                end
            end
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        fixp_lane_add #(
            .DATA_W    (DATA_W),
            .FRAC_DROP (FRAC_DROP),
            .ACC_LEN_W (ACC_LEN_W)
        ) u_lane (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .a        (bus.data_1_i[lane_lo(k, DATA_W) +: DATA_W]),
            .b        (bus.data_2_i[lane_lo(k, DATA_W) +: DATA_W]),
            .op       (op),
            .acc_step (acc_step),
            .emit     (emit),
            .relu     (relu1),
            .relu_out (s2_next[lane_lo(k, DATA_W) +: DATA_W])
        );
    end

    // Stage 2 and plain delay stages; data only moves with its valid so the output holds
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld <= '0;
            for (int k = 2; k <= PIPE_DEPTH; k++) dly[k] <= '0;
        end else begin
            vld[2] <= vld1;
            if (vld1) dly[2] <= s2_next;
            for (int k = 3; k <= PIPE_DEPTH; k++) begin
                vld[k] <= vld[k-1];
                if (vld[k-1]) dly[k] <= dly[k-1];
            end
        end
    end

    assign bus.valid_o    = vld[PIPE_DEPTH];
    assign bus.data_sum_o = dly[PIPE_DEPTH];
endmodule

// File: tb/tb_fixp_add_relu_pipe.sv
// tb/tb_fixp_add_relu_pipe.sv - directed self-checking bench, honours FIXP_ADD_SAT_EN
module tb_fixp_add_relu_pipe;
    localparam int DATA_W = 12;
    localparam int LANES  = 4;
    localparam int LAT    = 5;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    int          got_cyc[$];
    logic [11:0] got_d0[$];
    logic [11:0] got_d3[$];
    int          exp_cyc[$];
    logic [11:0] exp_d[$];

    always #5 clk_i = ~clk_i;

    fixp_add_relu_pipe_if #(.DATA_W(DATA_W), .LANES(LANES), .ACC_LEN_W(8)) bus ();

    fixp_add_relu_pipe dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
        cyc++;
        if (bus.valid_o) begin
            got_cyc.push_back(cyc);
            got_d0.push_back(bus.data_sum_o[11:0]);
            got_d3.push_back(bus.data_sum_o[47:36]);
        end
    endtask

    task automatic beat(input logic [11:0] a, input logic [11:0] b, input logic add,
                        input logic relu, input logic acc, input logic [7:0] len,
                        input logic out, input logic [11:0] exp);
        bus.valid_i   = 1'b1;
        bus.data_1_i  = {LANES{a}};
        bus.data_2_i  = {LANES{b}};
        bus.add_en_i  = add;
        bus.relu_en_i = relu;
        bus.acc_en_i  = acc;
        bus.acc_len_i = len;
        if (out) begin
            exp_cyc.push_back(cyc + LAT);
            exp_d.push_back(exp);
        end
        tick();
        bus.valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.valid_i = 1'b0;
        repeat (n) tick();
    endtask

    task automatic clear_q();
        got_cyc.delete(); got_d0.delete(); got_d3.delete();
        exp_cyc.delete(); exp_d.delete();
    endtask

    task automatic flush(input string tag);
        idle(LAT + 3);
        check_eq({tag, "_count"}, got_cyc.size(), exp_cyc.size());
        for (int i = 0; i < exp_cyc.size() && i < got_cyc.size(); i++) begin
            check_eq({tag, "_cycle"}, got_cyc[i], exp_cyc[i]);
            check_eq({tag, "_lane0"}, got_d0[i], exp_d[i]);
            check_eq({tag, "_lane3"}, got_d3[i], exp_d[i]);
        end
        clear_q();
    endtask

    initial begin
        logic [11:0] ovf_exp, ovf_relu_exp, neg_exp, accsat_exp;
`ifdef FIXP_ADD_SAT_EN
        ovf_exp = 12'h7F0; ovf_relu_exp = 12'h7F0; neg_exp = 12'h800; accsat_exp = 12'h7F0;
`else
        ovf_exp = 12'h800; ovf_relu_exp = 12'h000; neg_exp = 12'h700; accsat_exp = 12'h7D0;
`endif
        bus.valid_i = 1'b0; bus.data_1_i = '0; bus.data_2_i = '0;
        bus.add_en_i = 1'b0; bus.relu_en_i = 1'b0; bus.acc_en_i = 1'b0; bus.acc_len_i = '0;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        tick();
        check_eq("reset_valid", bus.valid_o, 1'b0);
        check_eq("reset_data", bus.data_sum_o, '0);
        clear_q();

        // Single add, then back-to-back add/pass/overflow/ReLU beats
        beat(12'h153, 12'h23F, 1, 0, 0, 0, 1, 12'h380);
        flush("add");
        beat(12'h153, 12'h23F, 0, 0, 0, 0, 1, 12'h153);
        beat(12'h7F0, 12'h010, 1, 0, 0, 0, 1, ovf_exp);
        beat(12'h7F0, 12'h010, 1, 1, 0, 0, 1, ovf_relu_exp);
        beat(12'hF00, 12'h050, 1, 1, 0, 0, 1, 12'h000);
        beat(12'hF00, 12'h050, 1, 0, 0, 0, 1, 12'hF50);
        beat(12'h800, 12'hF00, 1, 0, 0, 0, 1, neg_exp);
        flush("b2b");

        // Accumulate four beats
        beat(12'h010, 12'h000, 0, 0, 1, 3, 0, 0);
        beat(12'h020, 12'h000, 0, 0, 1, 3, 0, 0);
        beat(12'h030, 12'h000, 0, 0, 1, 3, 0, 0);
        beat(12'h040, 12'h000, 0, 0, 1, 3, 1, 12'h0A0);
        flush("acc4");

        // Length zero: every beat emitted, fraction cleared
        beat(12'h035, 12'h000, 0, 0, 1, 0, 1, 12'h030);
        beat(12'h05F, 12'h000, 0, 0, 1, 0, 1, 12'h050);
        flush("acc0");

        // Gaps inside an accumulation; mid-run length changes ignored
        beat(12'h010, 12'h000, 0, 0, 1, 2, 0, 0);
        idle(2);
        beat(12'h020, 12'h000, 0, 0, 1, 0, 0, 0);
        idle(1);
        beat(12'h030, 12'h000, 0, 0, 1, 7, 1, 12'h060);
        flush("gap");

        // Accumulator overflow: clamp or wrap
        beat(12'h7F0, 12'h000, 0, 0, 1, 2, 0, 0);
        beat(12'h7F0, 12'h000, 0, 0, 1, 2, 0, 0);
        beat(12'h7F0, 12'h000, 0, 0, 1, 2, 1, accsat_exp);
        flush("accovf");

        // Break: acc_en dropped after two beats, next beat is an add, then fresh run
        beat(12'h010, 12'h000, 0, 0, 1, 3, 0, 0);
        beat(12'h020, 12'h000, 0, 0, 1, 3, 0, 0);
        beat(12'h040, 12'h010, 1, 0, 0, 3, 1, 12'h050);
        beat(12'h010, 12'h000, 0, 0, 1, 1, 0, 0);
        beat(12'h010, 12'h000, 0, 0, 1, 1, 1, 12'h020);
        flush("break");

        // Async reset mid-accumulation with pass beats in flight
        beat(12'h111, 12'h000, 0, 0, 0, 0, 0, 0);
        beat(12'h222, 12'h000, 0, 0, 0, 0, 0, 0);
        beat(12'h333, 12'h000, 0, 0, 0, 0, 0, 0);
        beat(12'h010, 12'h000, 0, 0, 1, 3, 0, 0);
        beat(12'h020, 12'h000, 0, 0, 1, 3, 0, 0);
        check_eq("pre_reset_valid", bus.valid_o, 1'b1);
        #2 rst_i = 1'b1;
        #1;
        check_eq("rst_valid", bus.valid_o, 1'b0);
        check_eq("rst_data", bus.data_sum_o, '0);
        tick();
        rst_i = 1'b0;
        clear_q();
        flush("post_rst_quiet");
        beat(12'h010, 12'h000, 0, 0, 1, 1, 0, 0);
        beat(12'h020, 12'h000, 0, 0, 1, 1, 1, 12'h030);
        flush("post_rst_acc");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
